// File: rtl/apb_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl_if
//
// Groups every signal of the APB requester, apart from clock and reset:
//   command port  : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_wdata,
//                   cmd_strb
//   response port : rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   APB4 bus      : PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
//                   PRDATA, PREADY, PSLVERR
//
// Modports:
//   master : the controller (drives cmd_ready, the response and the APB bus)
//   slave  : the environment (issues commands, consumes responses and plays
//            the muxed APB completer)
// ---------------------------------------------------------------------------
interface apb_master_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic [NUM_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl
//
// APB4 requester. Takes one read/write command at a time from a valid/ready
// command port, runs the APB SETUP/ACCESS sequence towards the completer
// selected by the top address bits, honours PREADY wait states, and returns
// read data plus an error flag (PSLVERR, decode error or timeout) on a
// valid/ready response port. Every output is a flop.
//
// Ports:
//   apbClk : bus clock (single clock domain)
//   rst    : synchronous, active-high reset
//   bus    : apb_master_ctrl_if.master (command, response and APB signals)
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   : an ACCESS phase that sees PREADY low for TIMEOUT_CYCLES
//               cycles is aborted and answered with rsp_err = 1.
//   undefined : ACCESS waits for PREADY indefinitely; TIMEOUT_CYCLES only
//               takes part in the parameter sanity checks.
// ---------------------------------------------------------------------------
module apb_master_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              apbClk,
    input  logic              rst,
    apb_master_ctrl_if.master bus
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SEL_BITS   = $clog2(NUM_SLAVES);
    // Keeps the index vector legal when a single completer needs no select bits.
    localparam int IDX_W      = (SEL_BITS == 0) ? 1 : SEL_BITS;

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_data_width
        $error("apb_master_ctrl: DATA_WIDTH must be 8, 16 or 32");
    end
    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
        $error("apb_master_ctrl: NUM_SLAVES must be in 1..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;

`ifdef APB_TIMEOUT_EN
    // Counts the PREADY-low ACCESS cycles seen so far in the current transfer.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
`endif

    // Slave index taken from the top address bits of the incoming command.
    logic [IDX_W-1:0] cmd_idx;
    logic             decode_err;

    if (SEL_BITS == 0) begin : g_single_slave
        assign cmd_idx = '0;
    end else begin : g_decode
        assign cmd_idx = bus.cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];
    end

    // Only reachable when NUM_SLAVES is not a power of two.
    assign decode_err = (32'(cmd_idx) >= 32'(NUM_SLAVES));

    // Next-state and next-output logic. Every output has its own flop, so the
    // value each output should show in the next cycle is decided here.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
`ifdef APB_TIMEOUT_EN
        timeout_cnt_d = timeout_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                // Accept only when cmd_ready is actually visible, so the
                // first cycle after reset cannot take a command.
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (decode_err) begin
                        // No bus activity for an unmapped completer.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = SETUP;
                        psel_d    = NUM_SLAVES'(1) << cmd_idx;
                        penable_d = 1'b0;
                        paddr_d   = bus.cmd_addr;
                        pwrite_d  = bus.cmd_write;
                        // Reads never present data or strobes on the bus.
                        pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
                        pstrb_d   = bus.cmd_write ? bus.cmd_strb  : '0;
                    end
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                timeout_cnt_d = '0;
`endif
            end

            ACCESS: begin
                if (bus.PREADY) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_rdata_d = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    pwdata_d    = '0;
                    pstrb_d     = '0;
                end
`ifdef APB_TIMEOUT_EN
                // This wait cycle would make the count reach the limit.
                else if (timeout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    pwdata_d    = '0;
                    pstrb_d     = '0;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                end
`endif
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; an in-flight
    // transfer or pending response is simply dropped.
    always_ff @(posedge apbClk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            paddr_q     <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
`ifdef APB_TIMEOUT_EN
            timeout_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
`ifdef APB_TIMEOUT_EN
            timeout_cnt_q <= timeout_cnt_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_master_ctrl
//
// Self-checking bench for apb_master_ctrl with three completers (so the top
// select value 3 is a decode error). Each transaction is described by its
// command, wait-state count, slave error, read data and response delay; the
// expected cycle-by-cycle bus picture is derived from those transaction
// rules. Inputs change 1 ns after the rising edge, outputs are sampled on the
// falling edge. Honours APB_TIMEOUT_EN for the stalled-completer scenario.
// ---------------------------------------------------------------------------
module tb_apb_master_ctrl;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int NUM_SLAVES     = 3;
    localparam int TIMEOUT_CYCLES = 8;

    logic apbClk = 1'b0;
    logic rst    = 1'b1;

    int checkCount = 0;
    int errorCount = 0;

    // Model of the address/direction the bus keeps after a transfer.
    logic [31:0] lastPaddr  = '0;
    logic        lastPwrite = 1'b0;

    apb_master_ctrl_if #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_SLAVES(NUM_SLAVES)
    ) bus ();

    apb_master_ctrl #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_SLAVES    (NUM_SLAVES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .apbClk(apbClk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 apbClk = ~apbClk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, "_psel"},      bus.PSEL,      0);
        checkOutput({tag, "_penable"},   bus.PENABLE,   0);
        checkOutput({tag, "_pwrite"},    bus.PWRITE,    0);
        checkOutput({tag, "_paddr"},     bus.PADDR,     0);
        checkOutput({tag, "_pwdata"},    bus.PWDATA,    0);
        checkOutput({tag, "_pstrb"},     bus.PSTRB,     0);
        checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        checkOutput({tag, "_rsp_err"},   bus.rsp_err,   0);
        checkOutput({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    endtask

    task automatic checkPins(input string tag, input logic [2:0] sel, input logic en,
                             input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input logic rspValid);
        checkOutput({tag, "_psel"},      bus.PSEL,      sel);
        checkOutput({tag, "_penable"},   bus.PENABLE,   en);
        checkOutput({tag, "_pwrite"},    bus.PWRITE,    wr);
        checkOutput({tag, "_paddr"},     bus.PADDR,     addr);
        checkOutput({tag, "_pwdata"},    bus.PWDATA,    wdata);
        checkOutput({tag, "_pstrb"},     bus.PSTRB,     strb);
        checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, rspValid);
        checkOutput({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    endtask

    // Called with reset already applied, just after a rising edge.
    task automatic releaseReset(input string tag);
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        @(posedge apbClk); #1;
        @(negedge apbClk);
        checkOutput({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        checkOutput({tag, "_psel"},      bus.PSEL,      0);
        @(posedge apbClk); #1;
        lastPaddr  = '0;
        lastPwrite = 1'b0;
    endtask

    task automatic presentCmd(input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
    endtask

    // Scramble the command fields after acceptance; they must be ignored.
    task automatic scrambleCmd();
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_strb  = 4'($urandom_range(0, 15));
    endtask

    // One complete transaction, starting and ending just after a rising edge
    // with the controller idle and cmd_ready visible.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input int waits, input bit slvErr,
                                 input logic [31:0] rdata, input int rspDelay);
        int          idx;
        bit          decErr;
        logic [2:0]  expSel;
        logic [31:0] expWdata;
        logic [3:0]  expStrb;
        logic [31:0] expRdata;
        logic        expErr;

        idx      = int'(addr[31:30]);
        decErr   = (idx >= NUM_SLAVES);
        expSel   = decErr ? 3'b000 : 3'(1 << idx);
        expWdata = wr ? wdata : 32'h0;
        expStrb  = wr ? strb : 4'h0;

        presentCmd(wr, addr, wdata, strb);
        bus.rsp_ready = 1'($urandom_range(0, 1));
        @(negedge apbClk);
        checkOutput("idle_cmd_ready", bus.cmd_ready, 1);
        checkOutput("idle_rsp_valid", bus.rsp_valid, 0);
        checkOutput("idle_psel",      bus.PSEL,      0);
        @(posedge apbClk); #1;
        scrambleCmd();

        if (!decErr) begin
            lastPaddr  = addr;
            lastPwrite = wr;
            // SETUP: PREADY is don't-care here.
            bus.PREADY  = 1'($urandom_range(0, 1));
            bus.PSLVERR = 1'($urandom_range(0, 1));
            bus.PRDATA  = $urandom;
            @(negedge apbClk);
            checkPins("setup", expSel, 1'b0, wr, addr, expWdata, expStrb, 1'b0);
            @(posedge apbClk); #1;
            for (int w = 0; w <= waits; w++) begin
                bus.PREADY    = (w == waits);
                bus.PSLVERR   = (w == waits) ? slvErr : 1'($urandom_range(0, 1));
                bus.PRDATA    = (w == waits) ? rdata : $urandom;
                bus.rsp_ready = 1'($urandom_range(0, 1));
                @(negedge apbClk);
                checkPins("access", expSel, 1'b1, wr, addr, expWdata, expStrb, 1'b0);
                @(posedge apbClk); #1;
            end
            expErr   = slvErr;
            expRdata = (!wr && !slvErr) ? rdata : 32'h0;
        end else begin
            expErr   = 1'b1;
            expRdata = 32'h0;
        end

        for (int r = 0; r <= rspDelay; r++) begin
            bus.rsp_ready = (r == rspDelay);
            bus.PREADY    = 1'($urandom_range(0, 1));
            bus.cmd_valid = 1'($urandom_range(0, 1));
            @(negedge apbClk);
            checkPins("resp", 3'b000, 1'b0, lastPwrite, lastPaddr, 32'h0, 4'h0, 1'b1);
            checkOutput("resp_err",   bus.rsp_err,   expErr);
            checkOutput("resp_rdata", bus.rsp_rdata, expRdata);
            @(posedge apbClk); #1;
        end
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // Completer that never answers; checks the stall or timeout outcome.
    task automatic stallTest();
        int stillAccess;
        bit done;
        stillAccess = 0;
        done        = 1'b0;
        presentCmd(1'b0, 32'h4000_0100, 32'h0, 4'h0);
        @(negedge apbClk);
        checkOutput("stall_idle_cmd_ready", bus.cmd_ready, 1);
        @(posedge apbClk); #1;
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        @(posedge apbClk); #1;
`ifdef APB_TIMEOUT_EN
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge apbClk);
            if (bus.rsp_valid) done = 1'b1;
            else if (bus.PSEL == 3'b010 && bus.PENABLE) stillAccess++;
            if (!done) begin
                @(posedge apbClk); #1;
            end
        end
        checkOutput("timeout_reached",       done,          1);
        checkOutput("timeout_access_cycles", stillAccess,   TIMEOUT_CYCLES);
        checkOutput("timeout_rsp_err",       bus.rsp_err,   1);
        checkOutput("timeout_rsp_rdata",     bus.rsp_rdata, 0);
        checkOutput("timeout_psel",          bus.PSEL,      0);
        checkOutput("timeout_penable",       bus.PENABLE,   0);
        bus.rsp_ready = 1'b1;
        @(posedge apbClk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge apbClk);
        checkOutput("timeout_back_idle", bus.cmd_ready, 1);
        @(posedge apbClk); #1;
        lastPaddr  = 32'h4000_0100;
        lastPwrite = 1'b0;
`else
        for (int c = 0; c < 1000; c++) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
            @(negedge apbClk);
            if (bus.PSEL == 3'b010 && bus.PENABLE && !bus.rsp_valid && !bus.cmd_ready)
                stillAccess++;
            @(posedge apbClk); #1;
        end
        checkOutput("stall_access_cycles", stillAccess, 1000);
        rst = 1'b1;
        @(posedge apbClk); #1;
        @(negedge apbClk);
        checkAllReset("stall_rst");
        @(posedge apbClk); #1;
        releaseReset("stall_rel");
`endif
    endtask

    // Reset hitting the ACCESS phase of a write must drop it silently.
    task automatic resetTest();
        presentCmd(1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 4'h3);
        bus.PREADY = 1'b0;
        @(negedge apbClk);
        checkOutput("rstt_cmd_ready", bus.cmd_ready, 1);
        @(posedge apbClk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge apbClk); #1;
        @(negedge apbClk);
        checkOutput("rstt_access_penable", bus.PENABLE, 1);
        rst        = 1'b1;
        bus.PREADY = 1'b1;
        @(posedge apbClk); #1;
        @(negedge apbClk);
        checkAllReset("rstt_mid");
        @(posedge apbClk); #1;
        releaseReset("rstt_rel");
        @(negedge apbClk);
        checkOutput("rstt_no_rsp", bus.rsp_valid, 0);
        @(posedge apbClk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        rst           = 1'b1;

        repeat (2) @(posedge apbClk);
        #1;
        @(negedge apbClk);
        checkAllReset("por");
        @(posedge apbClk); #1;
        releaseReset("por_rel");

        // Directed cases.
        applyStimulus(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0);
        applyStimulus(1'b0, 32'h4000_0004, 32'h0, 4'h0, 3, 1'b0, 32'h1234_5678, 0);
        applyStimulus(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D, 0);
        applyStimulus(1'b0, 32'hC000_0000, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0);
        applyStimulus(1'b1, 32'h0000_0020, 32'h1111_2222, 4'h5, 1, 1'b1, 32'h0, 5);
        applyStimulus(1'b0, 32'h8000_0008, 32'h0, 4'h0, 2, 1'b1, 32'h7777_7777, 1);

        // Randomized traffic, including decode errors and idle gaps.
        for (int n = 0; n < 150; n++) begin
            int gap;
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                          4'($urandom_range(0, 15)), $urandom_range(0, 4),
                          ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
                @(negedge apbClk);
                checkOutput("gap_cmd_ready", bus.cmd_ready, 1);
                checkOutput("gap_rsp_valid", bus.rsp_valid, 0);
                checkOutput("gap_paddr",     bus.PADDR,     lastPaddr);
                checkOutput("gap_pwrite",    bus.PWRITE,    lastPwrite);
                @(posedge apbClk); #1;
            end
        end

        stallTest();
        resetTest();
        applyStimulus(1'b0, 32'h4000_0010, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_CAFE, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
